// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, opcode
// constants and instruction-word field positions.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_I = 3'd1,
        ST_WAIT_I  = 3'd2,
        ST_FETCH_M = 3'd3,
        ST_WAIT_M  = 3'd4,
        ST_EXEC    = 3'd5,
        ST_HALT    = 3'd6
    } fetch_state_t;

    localparam logic [2:0] OP_MVI    = 3'b001;
    localparam logic [6:0] HALT_MASK = 7'b1111111;

    localparam int OPC_MSB  = 8;
    localparam int OPC_LSB  = 6;
    localparam int X_MSB    = 5;
    localparam int X_LSB    = 3;
    localparam int Y_MSB    = 2;
    localparam int Y_LSB    = 0;
    localparam int HALT_MSB = 15;
    localparam int HALT_LSB = 9;

    function automatic logic is_halt(input logic [15:0] w);
        return w[HALT_MSB:HALT_LSB] == HALT_MASK;
    endfunction

    function automatic logic is_mvi(input logic [15:0] w);
        return w[OPC_MSB:OPC_LSB] == OP_MVI;
    endfunction

    function automatic logic [2:0] field_x(input logic [15:0] w);
        return w[X_MSB:X_LSB];
    endfunction

    function automatic logic [2:0] field_y(input logic [15:0] w);
        return w[Y_MSB:Y_LSB];
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: async reset, synchronous clear and increment, wraps
// naturally modulo 2^ADDR_W.
module pc_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= '0;
        end else if (i_clear) begin
            r_pc <= '0;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches instruction words (and the mvi immediate) from a synchronous ROM
// and presents them to the control unit, with HALT detection and a Done timeout.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_STEPS = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [15:0]       i_mem_data,
    output logic [15:0]       o_din,
    output logic              o_run,
    input  logic              i_done,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted,
    output logic              o_error
);

    localparam int CNT_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(MAX_STEPS - 1);

    fetch_state_t      r_state;
    fetch_state_t      w_next;
    logic [15:0]       r_instr;
    logic [15:0]       r_imm;
    logic [15:0]       r_din;
    logic              r_run;
    logic              r_error;
    logic [CNT_W-1:0]  r_step;
    logic [ADDR_W-1:0] w_pc;
    logic              w_pc_clear;
    logic              w_pc_inc;
    logic              w_mem_rd;
    logic              w_load_instr;
    logic              w_load_imm;
    logic              w_set_error;
    logic [15:0]       w_din_next;

    pc_counter #(.ADDR_W(ADDR_W)) u_pc (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_pc_clear),
        .i_inc   (w_pc_inc),
        .o_pc    (w_pc)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_pc_clear   = 1'b0;
        w_pc_inc     = 1'b0;
        w_mem_rd     = 1'b0;
        w_load_instr = 1'b0;
        w_load_imm   = 1'b0;
        w_set_error  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next     = ST_FETCH_I;
                    w_pc_clear = 1'b1;
                end
            end
            ST_FETCH_I: begin
                w_mem_rd = 1'b1;
                w_pc_inc = 1'b1;
                w_next   = ST_WAIT_I;
            end
            ST_WAIT_I: begin
                w_load_instr = 1'b1;
                if (is_halt(i_mem_data)) begin
                    w_next = ST_HALT;
                end else if (is_mvi(i_mem_data)) begin
                    w_next = ST_FETCH_M;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_FETCH_M: begin
                w_mem_rd = 1'b1;
                w_pc_inc = 1'b1;
                w_next   = ST_WAIT_M;
            end
            ST_WAIT_M: begin
                w_load_imm = 1'b1;
                w_next     = ST_EXEC;
            end
            ST_EXEC: begin
                // Done wins over the timeout when both land on the last step.
                if (i_done) begin
                    w_next = ST_FETCH_I;
                end else if (r_step == STEP_LAST) begin
                    w_next      = ST_HALT;
                    w_set_error = 1'b1;
                end
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // DIN is registered, so the first EXEC word is chosen on the entering edge.
    always_comb begin
        w_din_next = r_din;
        if (w_next == ST_EXEC) begin
            if (r_state == ST_WAIT_I) begin
                w_din_next = i_mem_data;
            end else if (r_state == ST_WAIT_M) begin
                w_din_next = r_instr;
            end else begin
                w_din_next = is_mvi(r_instr) ? r_imm : r_instr;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_instr <= '0;
            r_imm   <= '0;
            r_din   <= '0;
            r_run   <= 1'b0;
            r_error <= 1'b0;
            r_step  <= '0;
        end else begin
            if (w_load_instr) begin
                r_instr <= i_mem_data;
            end
            if (w_load_imm) begin
                r_imm <= i_mem_data;
            end
            if (w_set_error) begin
                r_error <= 1'b1;
            end
            r_din  <= w_din_next;
            r_run  <= (w_next == ST_EXEC);
            r_step <= (r_state == ST_EXEC && w_next == ST_EXEC) ? r_step + CNT_W'(1) : '0;
        end
    end

    assign o_mem_addr = w_mem_rd ? w_pc : '0;
    assign o_mem_rd   = w_mem_rd;
    assign o_din      = r_din;
    assign o_run      = r_run;
    assign o_pc       = w_pc;
    assign o_halted   = (r_state == ST_HALT);
    assign o_error    = r_error;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, hand-written corner
// sequences, a 2-bit-address wrap instance and a randomized program run.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data = 16'h0000;
    logic [15:0] din;
    logic        run;
    logic [7:0]  pc;
    logic        halted;
    logic        error;

    logic        s_start;
    logic        s_done;
    logic [1:0]  s_mem_addr;
    logic        s_mem_rd;
    logic [15:0] s_mem_data = 16'h0000;
    logic [15:0] s_din;
    logic        s_run;
    logic [1:0]  s_pc;
    logic        s_halted;
    logic        s_error;

    logic [15:0] rom   [0:255];
    logic [15:0] rom_s [0:3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd)   mem_data   <= rom[mem_addr];
    always @(posedge clk) if (s_mem_rd) s_mem_data <= rom_s[s_mem_addr];

    instr_fetch_unit #(.ADDR_W(8), .MAX_STEPS(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_mem_addr(mem_addr), .o_mem_rd(mem_rd), .i_mem_data(mem_data),
        .o_din(din), .o_run(run), .i_done(done), .o_pc(pc),
        .o_halted(halted), .o_error(error)
    );

    instr_fetch_unit #(.ADDR_W(2), .MAX_STEPS(4)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_start(s_start),
        .o_mem_addr(s_mem_addr), .o_mem_rd(s_mem_rd), .i_mem_data(s_mem_data),
        .o_din(s_din), .o_run(s_run), .i_done(s_done), .o_pc(s_pc),
        .o_halted(s_halted), .o_error(s_error)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] word;
        logic [15:0] imm;
        int          done_at;
        int          gap;
        logic [15:0] later;
        logic [7:0]  pc_after;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; start = 1'b0; done = 1'b0; s_start = 1'b0; s_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, " rst pc"}, pc, 0);
        chk({tag, " rst din"}, din, 0);
        chk({tag, " rst run"}, run, 0);
        chk({tag, " rst memrd"}, mem_rd, 0);
        chk({tag, " rst memaddr"}, mem_addr, 0);
        chk({tag, " rst halted"}, halted, 0);
        chk({tag, " rst error"}, error, 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Entered at the negedge of EXEC cycle 1. done_at=0 means never assert Done.
    task automatic exec_cycles(input string tag, input logic [15:0] word, input logic [15:0] later,
                               input logic [7:0] pc_after, input int done_at);
        for (int c = 1; c <= 4; c++) begin
            chk({tag, " run"}, run, 1);
            chk({tag, " din"}, din, (c == 1) ? word : later);
            chk({tag, " pc"}, pc, pc_after);
            chk({tag, " memrd"}, mem_rd, 0);
            if (c == done_at) begin
                done = 1'b1;
                return;
            end
            if (c < 4) @(negedge clk);
        end
        @(negedge clk);
        chk({tag, " timeout run"}, run, 0);
        chk({tag, " timeout halted"}, halted, 1);
        chk({tag, " timeout error"}, error, 1);
    endtask

    task automatic do_instr(input string tag, input logic [15:0] word, input logic [15:0] later,
                            input logic [7:0] pc_after, input int done_at, input int gap);
        int lows;
        lows = 0;
        @(negedge clk);
        done = 1'b0; start = 1'b0;
        while (run !== 1'b1 && lows < 12) begin
            lows++;
            @(negedge clk);
        end
        chk({tag, " gap"}, lows, gap);
        if (run === 1'b1) exec_cycles(tag, word, later, pc_after, done_at);
    endtask

    task automatic wait_halt(input string tag, input logic [7:0] exp_pc);
        int n;
        n = 0;
        @(negedge clk);
        done = 1'b0; start = 1'b0;
        chk({tag, " run dropped"}, run, 0);
        while (halted !== 1'b1 && n < 12) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " halted"}, halted, 1);
        chk({tag, " halt run"}, run, 0);
        chk({tag, " halt memrd"}, mem_rd, 0);
        chk({tag, " halt pc"}, pc, exp_pc);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        logic [15:0] sw [4];
        logic [15:0] sl [4];
        logic [1:0]  sp [4];
        int          sg [4];
        int          lows;
        int          p;

        tbl[0] = '{8'd0, 16'h0008, 16'h0000, 2, 2, 16'h0008, 8'd1};
        tbl[1] = '{8'd1, 16'h0081, 16'h0000, 4, 2, 16'h0081, 8'd2};
        tbl[2] = '{8'd2, 16'h0040, 16'hFE00, 2, 4, 16'hFE00, 8'd4};
        tbl[3] = '{8'd4, 16'h004F, 16'hA5A5, 1, 4, 16'hA5A5, 8'd6};
        tbl[4] = '{8'd6, 16'h01C0, 16'h0000, 1, 2, 16'h01C0, 8'd7};
        tbl[5] = '{8'd7, 16'h7FFF, 16'h0000, 3, 2, 16'h7FFF, 8'd8};

        rst = 1'b1; start = 1'b0; done = 1'b0; s_start = 1'b0; s_done = 1'b0;
        clear_rom();
        for (int a = 0; a < 4; a++) rom_s[a] = 16'h0000;

        // mvi R0 #1234 then HALT
        rom[0] = 16'h0040; rom[1] = 16'h1234; rom[2] = 16'hFE00;
        do_reset("t1");
        start = 1'b1;
        do_instr("t1 mvi", 16'h0040, 16'h1234, 8'd2, 2, 4);
        wait_halt("t1", 8'd3);

        // Vector table; Start is raised during each EXEC and must be ignored
        clear_rom();
        for (int i = 0; i < 6; i++) begin
            rom[tbl[i].addr] = tbl[i].word;
            if (tbl[i].gap == 4) rom[tbl[i].addr + 8'd1] = tbl[i].imm;
        end
        rom[8] = 16'hFE07;
        do_reset("tbl");
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) start = 1'b1;
            do_instr($sformatf("tbl%0d", i), tbl[i].word, tbl[i].later, tbl[i].pc_after,
                     tbl[i].done_at, tbl[i].gap);
        end
        wait_halt("tbl", 8'd9);

        // Timeout: Done never arrives
        clear_rom();
        rom[0] = 16'h0081;
        do_reset("to");
        start = 1'b1;
        do_instr("to", 16'h0081, 16'h0081, 8'd1, 0, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("to start ignored halted", halted, 1);
        chk("to start ignored memrd", mem_rd, 0);
        chk("to start ignored pc", pc, 1);
        chk("to error sticky", error, 1);
        chk("to run low", run, 0);

        // Reset mid-EXEC must clear outputs without a clock edge
        clear_rom();
        rom[0] = 16'h0040; rom[1] = 16'h5A5A;
        do_reset("mr");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mr fetch memrd", mem_rd, 1);
        chk("mr fetch addr", mem_addr, 0);
        lows = 0;
        while (run !== 1'b1 && lows < 12) begin
            lows++;
            @(negedge clk);
        end
        chk("mr in exec", run, 1);
        chk("mr pc before", pc, 2);
        rst = 1'b1;
        #1;
        chk("mr async run", run, 0);
        chk("mr async din", din, 0);
        chk("mr async pc", pc, 0);
        chk("mr async memrd", mem_rd, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr idle run", run, 0);
        chk("mr idle memrd", mem_rd, 0);
        chk("mr idle pc", pc, 0);
        chk("mr idle halted", halted, 0);

        // Done in IDLE and in FETCH_I/WAIT_I is ignored
        clear_rom();
        rom[0] = 16'h0008; rom[1] = 16'hFE00;
        done = 1'b1;
        repeat (3) @(negedge clk);
        chk("di idle memrd", mem_rd, 0);
        chk("di idle pc", pc, 0);
        chk("di idle run", run, 0);
        done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("dw fetch memrd", mem_rd, 1);
        done = 1'b1;
        @(negedge clk);
        chk("dw wait run", run, 0);
        chk("dw wait pc", pc, 1);
        @(negedge clk);
        done = 1'b0;
        exec_cycles("dw", 16'h0008, 16'h0008, 8'd1, 2);
        wait_halt("dw", 8'd2);

        // ADDR_W=2: mvi at the last address takes its immediate from address 0
        rom_s[0] = 16'hBEEF; rom_s[1] = 16'h0008; rom_s[2] = 16'h0008; rom_s[3] = 16'h0040;
        sw = '{16'hBEEF, 16'h0008, 16'h0008, 16'h0040};
        sl = '{16'hBEEF, 16'h0008, 16'h0008, 16'hBEEF};
        sp = '{2'd1, 2'd2, 2'd3, 2'd1};
        sg = '{2, 2, 2, 4};
        do_reset("wr");
        s_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_start = 1'b0; s_done = 1'b0;
            lows = 0;
            while (s_run !== 1'b1 && lows < 12) begin
                lows++;
                @(negedge clk);
            end
            chk($sformatf("wr%0d gap", i), lows, sg[i]);
            chk($sformatf("wr%0d din1", i), s_din, sw[i]);
            chk($sformatf("wr%0d pc", i), s_pc, sp[i]);
            @(negedge clk);
            chk($sformatf("wr%0d din2", i), s_din, sl[i]);
            chk($sformatf("wr%0d run2", i), s_run, 1);
            s_done = 1'b1;
        end
        @(negedge clk);
        s_done = 1'b0;

        // Randomized program against a PC/throughput reference model
        clear_rom();
        for (int a = 0; a < 256; a++) begin
            rom[a] = 16'($urandom) & 16'h7FFF;
            if ($urandom_range(0, 2) == 0) rom[a][8:6] = 3'b001;
        end
        do_reset("rnd");
        start = 1'b1;
        p = 0;
        for (int k = 0; k < 30; k++) begin
            logic [15:0] w;
            logic [15:0] im;
            logic        m;
            int          nxt;
            w   = rom[p];
            im  = rom[(p + 1) % 256];
            m   = (w[8:6] == 3'b001);
            nxt = (p + (m ? 2 : 1)) % 256;
            do_instr($sformatf("rnd%0d", k), w, m ? im : w, 8'(nxt),
                     $urandom_range(1, 4), m ? 4 : 2);
            p = nxt;
        end
        rom[p] = 16'hFF80;
        wait_halt("rnd", 8'((p + 1) % 256));
        chk("rnd no error", error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
